llc_lookup_way_pipe: RTL and testbench
======================================

LLC_LOOKUP_WAY_PIPE -- requirements
Module: llc_lookup_way_pipe

Interface
REQ-001 SHALL have parameter WAYS, default 16, set associativity (power of two, 2..32).
REQ-002 SHALL have parameter WAY_BITS, default $clog2(WAYS), way index width.
REQ-003 SHALL have parameter TAG_BITS, default 15, tag width.
REQ-004 SHALL have parameter CNT_BITS, default 16, statistics counter width.
REQ-005 SHALL have parameter REPL_MODE, default 0: 0 uses the external rotate base; 1 uses the internal round-robin pointer.
REQ-006 SHALL provide clk  input  1  sole clock; all state on the rising edge.
REQ-007 SHALL provide rst  input  1  reset, asynchronous and active-high.
REQ-008 SHALL provide in_valid  input  1 and in_ready  output  1: lookup request handshake.
REQ-009 SHALL provide in_tag  input  TAG_BITS  tag looked up.
REQ-010 SHALL provide in_tags  input  WAYS x TAG_BITS  and in_states  input  WAYS x llc_state_t: per-way set contents.
REQ-011 SHALL provide in_evict_way  input  WAY_BITS  external rotate base, used only when REPL_MODE=0.
REQ-012 SHALL provide out_valid  output  1 and out_ready  input  1: result handshake.
REQ-013 SHALL provide out_way  output  WAY_BITS, out_evict  output  1, out_hit  output  1: the registered result.
REQ-014 SHALL provide cnt_clr  input  1, hit_cnt  output  CNT_BITS, evict_cnt  output  CNT_BITS.

Function
REQ-015 SHALL drive in_ready = !out_valid || out_ready (one-deep pipeline register).
REQ-016 SHALL accept a request on in_valid && in_ready and present its result on out_* the next cycle (latency 1).
REQ-017 SHALL hold out_way, out_evict and out_hit stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid after out_ready when no new request is accepted in the same cycle.
REQ-019 SHALL treat way i as a hit when in_tags[i]==in_tag and in_states[i]!=INVALID.
REQ-020 SHALL use base = in_evict_way (mode 0) or rr_ptr (mode 1).
REQ-021 SHALL select the way by this priority:
- lowest-index hit -> out_hit=1, out_evict=0.
- else lowest-index INVALID way -> out_evict=0.
- else first VALID way scanning from base upward -> out_evict=1.
- else first non-SD way scanning from base upward -> out_evict=1.
- else base -> out_evict=1.
REQ-022 SHALL compute every scan index as (base+i) mod WAYS, wrapping from WAYS-1 to 0.
REQ-023 SHALL, in mode 1, set rr_ptr to (chosen way + 1) mod WAYS on each accepted lookup that evicts, and leave it unchanged otherwise.
REQ-024 SHALL increment hit_cnt for each accepted hit and evict_cnt for each accepted eviction, saturating at all-ones.
REQ-025 SHALL give cnt_clr priority over a same-cycle increment: both counters go to 0.
REQ-026 SHALL latch the result from the inputs sampled in the acceptance cycle only; input changes while stalled have no effect.

Reset
REQ-027 SHALL, on rst, immediately drive out_valid=0, out_way=0, out_evict=0, out_hit=0, rr_ptr=0, hit_cnt=0, evict_cnt=0.
REQ-028 SHALL discard any in-flight result when rst asserts mid-operation; in_ready=1 in the first cycle after release.

Structure
REQ-029 SHALL take llc_state_t and the INVALID, VALID and SD encodings from the shared cache types/constants package; no local redefinition.
REQ-030 SHALL instantiate pri_enc (the existing priority-encoder sub-module) once per search: hit, empty, valid-evict and not-SD-evict.
REQ-031 SHALL keep the rotate/unrotate arithmetic local and WAY_BITS wide, with natural truncation.

Verification
REQ-032 Hit: WAYS=16, way 5 tag match with state VALID, way 2 INVALID -> out_way=5, out_hit=1, out_evict=0, hit_cnt=1, one cycle after acceptance.
REQ-033 Wrap eviction: mode 0, in_evict_way=14, all ways VALID except 14 and 15 in SD -> out_way=0, out_evict=1.
REQ-034 Round-robin: mode 1, three back-to-back full-set misses with all ways VALID -> out_way=0,1,2; rr_ptr=3; evict_cnt=3.
REQ-035 Backpressure: out_ready=0 for 4 cycles with in_valid=1 and changing inputs -> in_ready=0 and out_* frozen; the request is accepted in the cycle out_ready rises.
REQ-036 All ways SD, base=7 -> out_way=7, out_evict=1.
REQ-037 Counters: CNT_BITS=4, 17 hits -> hit_cnt=15; cnt_clr together with a hit -> hit_cnt=0; rst mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/llc_lookup_way_pipe_pkg.sv
// llc_lookup_way_pipe_pkg: shared cache line state encodings used by the lookup pipeline
package llc_lookup_way_pipe_pkg;
   typedef enum logic [1:0] {
      INVALID = 2'd0,
      VALID   = 2'd1,
      SC      = 2'd2,
      SD      = 2'd3
   } llc_state_t;
   localparam int STATE_BITS = $bits(llc_state_t);
endpackage

// File: rtl/llc_lookup_way_pipe_pri_enc.sv
// pri_enc: lowest-index priority encoder with a found flag
module pri_enc #(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic         found,
   output logic [W-1:0] idx
);
   always_comb begin
      found = |req;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
   end
endmodule

// File: rtl/llc_lookup_way_pipe.sv
// llc_lookup_way_pipe: one-deep registered LLC way lookup with hit/fill/evict selection,
// selectable rotate base and saturating hit/evict statistics.
module llc_lookup_way_pipe
   import llc_lookup_way_pipe_pkg::*;
#(
   parameter int WAYS      = 16,
   parameter int WAY_BITS  = $clog2(WAYS),
   parameter int TAG_BITS  = 15,
   parameter int CNT_BITS  = 16,
   parameter int REPL_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [TAG_BITS-1:0]        in_tag,
   input  logic [WAYS*TAG_BITS-1:0]   in_tags,
   input  logic [WAYS*STATE_BITS-1:0] in_states,
   input  logic [WAY_BITS-1:0]        in_evict_way,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WAY_BITS-1:0]        out_way,
   output logic                       out_evict,
   output logic                       out_hit,
   input  logic                       cnt_clr,
   output logic [CNT_BITS-1:0]        hit_cnt,
   output logic [CNT_BITS-1:0]        evict_cnt
);
   logic [WAY_BITS-1:0] rr_ptr, base, hit_idx, inv_idx, val_off, nsd_off, way;
   logic [WAYS-1:0] hit_vec, inv_vec, val_rot, nsd_rot;
   logic hit_any, inv_any, val_any, nsd_any, evict, accept;

   assign base = (REPL_MODE == 1) ? rr_ptr : in_evict_way;
   assign in_ready = !out_valid || out_ready;
   assign accept = in_valid && in_ready;

   // The eviction searches run on a view rotated so that bit 0 is the base way.
   for (genvar i = 0; i < WAYS; i++) begin : g_way
      logic [WAY_BITS-1:0] r;
      llc_state_t s, sr;
      assign r = base + WAY_BITS'(i);
      assign s = llc_state_t'(in_states[i*STATE_BITS +: STATE_BITS]);
      assign sr = llc_state_t'(in_states[r*STATE_BITS +: STATE_BITS]);
      assign hit_vec[i] = (in_tags[i*TAG_BITS +: TAG_BITS] == in_tag) && (s != INVALID);
      assign inv_vec[i] = (s == INVALID);
      assign val_rot[i] = (sr == VALID);
      assign nsd_rot[i] = (sr != SD);
   end

   pri_enc #(.N(WAYS), .W(WAY_BITS)) u_hit (.req(hit_vec), .found(hit_any), .idx(hit_idx));
   pri_enc #(.N(WAYS), .W(WAY_BITS)) u_inv (.req(inv_vec), .found(inv_any), .idx(inv_idx));
   pri_enc #(.N(WAYS), .W(WAY_BITS)) u_val (.req(val_rot), .found(val_any), .idx(val_off));
   pri_enc #(.N(WAYS), .W(WAY_BITS)) u_nsd (.req(nsd_rot), .found(nsd_any), .idx(nsd_off));

   assign evict = !hit_any && !inv_any;
   assign way = hit_any ? hit_idx :
                inv_any ? inv_idx :
                val_any ? base + val_off :
                nsd_any ? base + nsd_off : base;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_way <= '0;
         out_evict <= 1'b0;
         out_hit <= 1'b0;
         rr_ptr <= '0;
         hit_cnt <= '0;
         evict_cnt <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_way <= way;
            out_evict <= evict;
            out_hit <= hit_any;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (REPL_MODE == 1 && accept && evict) rr_ptr <= way + WAY_BITS'(1);
         if (cnt_clr) begin
            hit_cnt <= '0;
            evict_cnt <= '0;
         end else begin
            if (accept && hit_any && !(&hit_cnt)) hit_cnt <= hit_cnt + CNT_BITS'(1);
            if (accept && evict && !(&evict_cnt)) evict_cnt <= evict_cnt + CNT_BITS'(1);
         end
      end
   end
endmodule

// File: tb/tb_llc_lookup_way_pipe.sv
// tb_llc_lookup_way_pipe: directed and random lookups on a rotate-base and a round-robin
// instance sharing one stimulus, checked against a behavioural way-selection model.
module tb_llc_lookup_way_pipe;
   import llc_lookup_way_pipe_pkg::*;
   localparam int WAYS = 16, WB = 4, TB = 15, CB = 4;

   logic clk = 0, rst = 0;
   logic in_valid = 0, out_ready = 0, cnt_clr = 0;
   logic [TB-1:0] in_tag = '0;
   logic [WAYS*TB-1:0] in_tags = '0;
   logic [WAYS*STATE_BITS-1:0] in_states = '0;
   logic [WB-1:0] in_evict_way = '0;
   logic [1:0] in_ready, out_valid, out_evict, out_hit;
   logic [WB-1:0] out_way [2];
   logic [CB-1:0] hit_cnt [2], evict_cnt [2];

   int n_vec = 0, n_err = 0;
   int m_valid, m_way[2], m_ev[2], m_hit[2], m_rr[2], m_hc[2], m_ec[2];

   always #5 clk = ~clk;

   llc_lookup_way_pipe #(.WAYS(WAYS), .TAG_BITS(TB), .CNT_BITS(CB), .REPL_MODE(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_tag(in_tag),
      .in_tags(in_tags), .in_states(in_states), .in_evict_way(in_evict_way),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_way(out_way[0]),
      .out_evict(out_evict[0]), .out_hit(out_hit[0]), .cnt_clr(cnt_clr),
      .hit_cnt(hit_cnt[0]), .evict_cnt(evict_cnt[0]));

   llc_lookup_way_pipe #(.WAYS(WAYS), .TAG_BITS(TB), .CNT_BITS(CB), .REPL_MODE(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_tag(in_tag),
      .in_tags(in_tags), .in_states(in_states), .in_evict_way(in_evict_way),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_way(out_way[1]),
      .out_evict(out_evict[1]), .out_hit(out_hit[1]), .cnt_clr(cnt_clr),
      .hit_cnt(hit_cnt[1]), .evict_cnt(evict_cnt[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] st(input int i);
      return in_states[i*STATE_BITS +: STATE_BITS];
   endfunction

   // Returns {hit, evict, way[3:0]} following the way-selection priority list.
   function automatic logic [5:0] ref_lookup(input int b);
      for (int i = 0; i < WAYS; i++)
         if (in_tags[i*TB +: TB] == in_tag && st(i) != INVALID) return {2'b10, 4'(i)};
      for (int i = 0; i < WAYS; i++)
         if (st(i) == INVALID) return {2'b00, 4'(i)};
      for (int k = 0; k < WAYS; k++)
         if (st((b + k) % WAYS) == VALID) return {2'b01, 4'((b + k) % WAYS)};
      for (int k = 0; k < WAYS; k++)
         if (st((b + k) % WAYS) != SD) return {2'b01, 4'((b + k) % WAYS)};
      return {2'b01, 4'(b)};
   endfunction

   task automatic model_reset();
      m_valid = 0;
      for (int m = 0; m < 2; m++) begin
         m_way[m] = 0; m_ev[m] = 0; m_hit[m] = 0; m_rr[m] = 0; m_hc[m] = 0; m_ec[m] = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      #1;
      model_reset();
      chk("rst_out_valid0", out_valid[0], 0);
      chk("rst_out_valid1", out_valid[1], 0);
      chk("rst_hit_cnt", hit_cnt[0], 0);
      @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic step();
      logic acc;
      logic [5:0] r [2];
      #1;
      chk("in_ready0", in_ready[0], (!m_valid || out_ready) ? 1 : 0);
      chk("in_ready1", in_ready[1], (!m_valid || out_ready) ? 1 : 0);
      acc = in_valid && (!m_valid || out_ready);
      r[0] = ref_lookup(int'(in_evict_way));
      r[1] = ref_lookup(m_rr[1]);
      @(posedge clk);
      #1;
      if (acc) m_valid = 1;
      else if (out_ready) m_valid = 0;
      for (int m = 0; m < 2; m++) begin
         if (acc) begin
            m_hit[m] = r[m][5]; m_ev[m] = r[m][4]; m_way[m] = r[m][3:0];
            if (m == 1 && r[m][4]) m_rr[m] = (r[m][3:0] + 1) % WAYS;
         end
         if (cnt_clr) begin
            m_hc[m] = 0; m_ec[m] = 0;
         end else if (acc) begin
            if (r[m][5] && m_hc[m] < 15) m_hc[m]++;
            if (r[m][4] && m_ec[m] < 15) m_ec[m]++;
         end
         chk("out_valid", out_valid[m], m_valid);
         chk("out_way", out_way[m], m_way[m]);
         chk("out_evict", out_evict[m], m_ev[m]);
         chk("out_hit", out_hit[m], m_hit[m]);
         chk("hit_cnt", hit_cnt[m], m_hc[m]);
         chk("evict_cnt", evict_cnt[m], m_ec[m]);
      end
   endtask

   task automatic fill(input logic [1:0] s);
      for (int i = 0; i < WAYS; i++) begin
         in_tags[i*TB +: TB] = TB'(i);
         in_states[i*STATE_BITS +: STATE_BITS] = s;
      end
   endtask

   task automatic set_way(input int i, input logic [TB-1:0] t, input logic [1:0] s);
      in_tags[i*TB +: TB] = t;
      in_states[i*STATE_BITS +: STATE_BITS] = s;
   endtask

   task automatic randomize_inputs();
      in_tag = TB'($urandom_range(0, 3));
      in_evict_way = WB'($urandom);
      for (int i = 0; i < WAYS; i++) set_way(i, TB'($urandom_range(0, 3)), 2'($urandom));
   endtask

   logic [WB-1:0] held;

   initial begin
      do_reset();
      // Hit on way 5 beats the empty way 2.
      out_ready = 1; in_valid = 1; in_tag = 15'h1234;
      fill(VALID); set_way(5, 15'h1234, VALID); set_way(2, 15'h0, INVALID);
      step();
      chk("hit_way", out_way[0], 5);
      chk("hit_flag", out_hit[0], 1);
      chk("hit_cnt1", hit_cnt[0], 1);
      // Rotate-base eviction wrapping past the SD ways 14 and 15.
      fill(VALID); set_way(14, 15'h0, SD); set_way(15, 15'h0, SD); in_evict_way = 14;
      step();
      chk("wrap_way", out_way[0], 0);
      chk("wrap_evict", out_evict[0], 1);
      // Round-robin over back-to-back full-set misses.
      do_reset();
      out_ready = 1; in_valid = 1; fill(VALID); in_evict_way = 9;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rr_way", out_way[1], k);
      end
      chk("rr_evict_cnt", evict_cnt[1], 3);
      step();
      chk("rr_ptr3", out_way[1], 3);
      // Every way SD: fall back to the base itself.
      fill(SD); in_evict_way = 7;
      step();
      chk("allsd_way", out_way[0], 7);
      chk("allsd_evict", out_evict[0], 1);
      // Backpressure with changing inputs while stalled.
      fill(VALID); set_way(3, 15'h0, INVALID); in_tag = 15'h7777;
      step();
      held = out_way[0];
      out_ready = 0;
      for (int k = 0; k < 4; k++) begin
         randomize_inputs();
         step();
         chk("bp_hold", out_way[0], held);
      end
      out_ready = 1;
      step();
      // Counter saturation and clear priority.
      do_reset();
      out_ready = 1; in_valid = 1; in_tag = 15'h1234;
      fill(VALID); set_way(5, 15'h1234, VALID);
      for (int k = 0; k < 17; k++) step();
      chk("sat_hit_cnt", hit_cnt[0], 15);
      cnt_clr = 1;
      step();
      chk("clr_hit_cnt", hit_cnt[0], 0);
      cnt_clr = 0;
      // Reset while stalled drops the held result.
      out_ready = 0;
      step();
      step();
      do_reset();
      out_ready = 1;
      step();
      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         cnt_clr = ($urandom_range(0, 19) == 0);
         randomize_inputs();
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
